// File: rtl/mips_dmem_bridge.sv
// mips_dmem_bridge
//   Data-side memory subsystem for the single-cycle MIPS core. Ordinary
//   addresses hit an internal word RAM. The top 64 KiB (aluout[31:16] ==
//   16'hFFFF) hit memory-mapped peripherals: an 8-bit output port, a byte
//   TX FIFO with a valid/ready handshake, and an optional cycle timer.
//   Loads are combinational so the core sees data in the same cycle.
//
// Build option:
//   MMIO_TIMER_EN - when defined, a 32-bit free-running timer lives at
//                   offset 0x000C. When undefined, no timer flops exist and
//                   that offset reads 0 and ignores writes.
//
// Ports:
//   clk        rising-edge clock shared with the core
//   reset      asynchronous active-low reset (0 = reset)
//   memwrite   store strobe from the core
//   aluout     byte address from the core (word access, bits [1:0] ignored)
//   writedata  store data from the core
//   readdata   combinational load data to the core
//   tx_data    FIFO head byte
//   tx_valid   FIFO non-empty
//   tx_ready   sink accepts tx_data this cycle
//   out_port   output port register
module mips_dmem_bridge #(
  parameter int RAM_WORDS  = 64,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memwrite,
  input  logic [31:0] aluout,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [7:0]  out_port
);

  localparam int AW = $clog2(RAM_WORDS);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);

  // Storage arrays: neither is reset. FIFO bytes are discarded on reset by
  // clearing the count and pointers, not by clearing the buffer.
  logic [31:0] ram_mem  [RAM_WORDS];
  logic [7:0]  fifo_buf [FIFO_DEPTH];

  logic [7:0]    out_port_q, out_port_d;
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;

  logic          is_mmio;
  logic [13:0]   mmio_word;
  logic          sel_out, sel_tx, sel_stat;
  logic [AW-1:0] ram_idx;
  logic          ram_we;
  logic          fifo_full, fifo_empty;
  logic          push_req, push, pop;
  logic [31:0]   status_word;
  logic          unused_addr_bits;

  // Byte-offset bits are meaningless for word access; only kept to show
  // they are deliberately ignored.
  assign unused_addr_bits = ^aluout[1:0];

  assign is_mmio   = (aluout[31:16] == 16'hFFFF);
  assign mmio_word = aluout[15:2];
  assign sel_out   = is_mmio && (mmio_word == 14'd0);
  assign sel_tx    = is_mmio && (mmio_word == 14'd1);
  assign sel_stat  = is_mmio && (mmio_word == 14'd2);

  // Upper address bits above the RAM index alias onto the same words.
  assign ram_idx = aluout[AW+1:2];
  assign ram_we  = memwrite && !is_mmio;

  assign fifo_full  = (count_q == FULL_COUNT);
  assign fifo_empty = (count_q == '0);
  assign tx_valid   = !fifo_empty;
  assign tx_data    = fifo_buf[rptr_q];
  assign out_port   = out_port_q;

  assign status_word = {16'h0000, 8'(count_q), 5'b00000, ovf_q, fifo_full, fifo_empty};

`ifdef MMIO_TIMER_EN
  logic        sel_tim;
  logic [31:0] timer_q, timer_d;

  assign sel_tim = is_mmio && (mmio_word == 14'd3);

  // A store to the timer wins over the increment.
  always_comb begin
    timer_d = timer_q + 32'd1;
    if (memwrite && sel_tim) begin
      timer_d = writedata;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_d;
    end
  end
`endif

  // Full is sampled before the edge, so a push into a full FIFO is dropped
  // even when a pop frees a slot in the same cycle.
  always_comb begin
    push_req   = memwrite && sel_tx;
    push       = push_req && !fifo_full;
    pop        = tx_valid && tx_ready;
    out_port_d = out_port_q;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    count_d    = count_q + CW'(push) - CW'(pop);
    ovf_d      = ovf_q;
    if (memwrite && sel_out) begin
      out_port_d = writedata[7:0];
    end
    if (push) begin
      wptr_d = wptr_q + PW'(1);
    end
    if (pop) begin
      rptr_d = rptr_q + PW'(1);
    end
    if (push_req && fifo_full) begin
      ovf_d = 1'b1;
    end
    if (memwrite && sel_stat && writedata[2]) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_port_q <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      ovf_q      <= 1'b0;
    end else begin
      out_port_q <= out_port_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      ovf_q      <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (ram_we) begin
      ram_mem[ram_idx] <= writedata;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_buf[wptr_q] <= writedata[7:0];
    end
  end

  // Zero-latency load mux for the single-cycle core.
  always_comb begin
    readdata = 32'h0;
    if (!is_mmio) begin
      readdata = ram_mem[ram_idx];
    end else if (sel_out) begin
      readdata = {24'h000000, out_port_q};
    end else if (sel_stat) begin
      readdata = status_word;
    end
`ifdef MMIO_TIMER_EN
    else if (sel_tim) begin
      readdata = timer_q;
    end
`endif
  end

endmodule

// File: tb/tb_mips_dmem_bridge.sv
// Directed bench for mips_dmem_bridge: RAM, output port, TX FIFO (fill,
// overflow, drain, simultaneous push/pop), timer and asynchronous reset.
module tb_mips_dmem_bridge;

  localparam int RAM_WORDS  = 64;
  localparam int FIFO_DEPTH = 8;

  localparam logic [31:0] A_OUT  = 32'hFFFF_0000;
  localparam logic [31:0] A_TX   = 32'hFFFF_0004;
  localparam logic [31:0] A_STAT = 32'hFFFF_0008;
  localparam logic [31:0] A_TIM  = 32'hFFFF_000C;

  logic        clk = 1'b0;
  logic        reset;
  logic        memwrite;
  logic [31:0] aluout;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  out_port;

  int checks = 0;
  int errors = 0;

  mips_dmem_bridge #(.RAM_WORDS(RAM_WORDS), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .reset(reset), .memwrite(memwrite), .aluout(aluout),
    .writedata(writedata), .readdata(readdata), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .out_port(out_port)
  );

  always #5 clk = ~clk;

  // Stimulus helpers; callers always sit 1 ns after a rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data);
    aluout    = addr;
    writedata = data;
    memwrite  = 1'b1;
    @(posedge clk);
    #1;
    memwrite  = 1'b0;
  endtask

  task automatic rd(input logic [31:0] addr, output logic [31:0] data);
    memwrite = 1'b0;
    aluout   = addr;
    #1;
    data = readdata;
  endtask

  task automatic test_reset();
    logic [31:0] v;
    reset = 1'b0; memwrite = 1'b0; tx_ready = 1'b0;
    aluout = '0; writedata = '0;
    #2;
    rd(A_STAT, v);
    checks++; if (v !== 32'h1) begin errors++; $display("[TB] FAIL reset_status got %h exp %h", v, 32'h1); end
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_tx_valid got %b exp 0", tx_valid); end
    checks++; if (out_port !== 8'h00) begin errors++; $display("[TB] FAIL reset_out_port got %h exp 00", out_port); end
    tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic test_ram();
    logic [31:0] v;
    do_write(32'h10, 32'hDEADBEEF);
    do_write(32'h20, 32'h12345678);
    rd(32'h10, v);
    checks++; if (v !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL ram_read got %h exp DEADBEEF", v); end
    rd(32'h10 + RAM_WORDS * 4, v);
    checks++; if (v !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL ram_alias got %h exp DEADBEEF", v); end
    tick();
    rd(32'h13, v);
    checks++; if (v !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL ram_byteoff got %h exp DEADBEEF", v); end
    rd(32'h20, v);
    checks++; if (v !== 32'h12345678) begin errors++; $display("[TB] FAIL ram_word2 got %h exp 12345678", v); end
    // MMIO stores must not leak into the RAM word with the same low index.
    do_write(32'hFFFF_0010, 32'h0BAD0BAD);
    rd(32'h10, v);
    checks++; if (v !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL ram_mmio_leak got %h exp DEADBEEF", v); end
  endtask

  task automatic test_outport();
    logic [31:0] v;
    do_write(A_OUT, 32'h123456A5);
    checks++; if (out_port !== 8'hA5) begin errors++; $display("[TB] FAIL outport_pin got %h exp A5", out_port); end
    rd(A_OUT, v);
    checks++; if (v !== 32'h000000A5) begin errors++; $display("[TB] FAIL outport_read got %h exp 000000A5", v); end
    do_write(32'hFFFF_0020, 32'hFFFFFFFF);
    checks++; if (out_port !== 8'hA5) begin errors++; $display("[TB] FAIL unmapped_wr got %h exp A5", out_port); end
    rd(32'hFFFF_0020, v);
    checks++; if (v !== 32'h0) begin errors++; $display("[TB] FAIL unmapped_rd got %h exp 0", v); end
    rd(32'h20, v);
    checks++; if (v !== 32'h12345678) begin errors++; $display("[TB] FAIL unmapped_ram got %h exp 12345678", v); end
  endtask

  task automatic test_fifo_fill();
    logic [31:0] v;
    logic [7:0]  e;
    tx_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      do_write(A_TX, 32'h41 + i);
      if (i == 0) begin
        checks++; if (tx_valid !== 1'b1 || tx_data !== 8'h41) begin errors++; $display("[TB] FAIL first_push got v=%b d=%h exp v=1 d=41", tx_valid, tx_data); end
      end
    end
    rd(A_STAT, v);
    checks++; if (v !== 32'h00000802) begin errors++; $display("[TB] FAIL fifo_full_stat got %h exp 00000802", v); end
    rd(A_TX, v);
    checks++; if (v !== 32'h0) begin errors++; $display("[TB] FAIL txdata_read got %h exp 0", v); end
    do_write(A_TX, 32'h49);
    rd(A_STAT, v);
    checks++; if (v !== 32'h00000806) begin errors++; $display("[TB] FAIL fifo_ovf_stat got %h exp 00000806", v); end
    tick();
    tx_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      e = 8'h41 + 8'(i);
      checks++; if (tx_valid !== 1'b1 || tx_data !== e) begin errors++; $display("[TB] FAIL drain got v=%b d=%h exp v=1 d=%h", tx_valid, tx_data, e); end
      tick();
    end
    tx_ready = 1'b0;
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("[TB] FAIL drain_empty got %b exp 0", tx_valid); end
    rd(A_STAT, v);
    checks++; if (v !== 32'h00000005) begin errors++; $display("[TB] FAIL drain_stat got %h exp 00000005", v); end
    do_write(A_STAT, 32'h4);
    rd(A_STAT, v);
    checks++; if (v !== 32'h00000001) begin errors++; $display("[TB] FAIL ovf_clear got %h exp 00000001", v); end
  endtask

  task automatic test_full_push_pop();
    logic [31:0] v;
    logic [7:0]  e;
    tx_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      do_write(A_TX, 32'h50 + i);
    end
    tx_ready = 1'b1;
    do_write(A_TX, 32'h58);
    tx_ready = 1'b0;
    rd(A_STAT, v);
    checks++; if (v !== 32'h00000704) begin errors++; $display("[TB] FAIL full_pp_stat got %h exp 00000704", v); end
    tick();
    tx_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      e = 8'h51 + 8'(i);
      checks++; if (tx_valid !== 1'b1 || tx_data !== e) begin errors++; $display("[TB] FAIL full_pp_drain got v=%b d=%h exp v=1 d=%h", tx_valid, tx_data, e); end
      tick();
    end
    tx_ready = 1'b0;
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("[TB] FAIL full_pp_empty got %b exp 0", tx_valid); end
    do_write(A_STAT, 32'h4);
    rd(A_STAT, v);
    checks++; if (v !== 32'h00000001) begin errors++; $display("[TB] FAIL full_pp_clear got %h exp 00000001", v); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] v;
    logic [7:0]  e;
    tx_ready = 1'b0;
    do_write(A_TX, 32'h61);
    do_write(A_TX, 32'h62);
    do_write(A_TX, 32'h63);
    rd(A_STAT, v);
    checks++; if (v !== 32'h00000300) begin errors++; $display("[TB] FAIL b2b_pre got %h exp 00000300", v); end
    tx_ready = 1'b1;
    do_write(A_TX, 32'h64);
    tx_ready = 1'b0;
    rd(A_STAT, v);
    checks++; if (v !== 32'h00000300) begin errors++; $display("[TB] FAIL b2b_post got %h exp 00000300", v); end
    tick();
    tx_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      e = 8'h62 + 8'(i);
      checks++; if (tx_valid !== 1'b1 || tx_data !== e) begin errors++; $display("[TB] FAIL b2b_order got v=%b d=%h exp v=1 d=%h", tx_valid, tx_data, e); end
      tick();
    end
    tx_ready = 1'b0;
    rd(A_STAT, v);
    checks++; if (v !== 32'h00000001) begin errors++; $display("[TB] FAIL b2b_empty got %h exp 00000001", v); end
  endtask

  task automatic test_timer();
    logic [31:0] v;
`ifdef MMIO_TIMER_EN
    do_write(A_TIM, 32'hFFFFFFFE);
    rd(A_TIM, v);
    checks++; if (v !== 32'hFFFFFFFE) begin errors++; $display("[TB] FAIL timer_0 got %h exp FFFFFFFE", v); end
    tick();
    rd(A_TIM, v);
    checks++; if (v !== 32'hFFFFFFFF) begin errors++; $display("[TB] FAIL timer_1 got %h exp FFFFFFFF", v); end
    tick();
    rd(A_TIM, v);
    checks++; if (v !== 32'h00000000) begin errors++; $display("[TB] FAIL timer_wrap got %h exp 00000000", v); end
`else
    rd(A_TIM, v);
    checks++; if (v !== 32'h0) begin errors++; $display("[TB] FAIL timer_absent got %h exp 0", v); end
    do_write(A_TIM, 32'h12345678);
    rd(A_TIM, v);
    checks++; if (v !== 32'h0) begin errors++; $display("[TB] FAIL timer_absent_wr got %h exp 0", v); end
`endif
  endtask

  task automatic test_reset_mid();
    logic [31:0] v;
    tx_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      do_write(A_TX, 32'h71 + i);
    end
    do_write(A_OUT, 32'h3C);
    do_write(32'h30, 32'hCAFEF00D);
    checks++; if (tx_valid !== 1'b1 || out_port !== 8'h3C) begin errors++; $display("[TB] FAIL pre_reset got v=%b o=%h exp v=1 o=3C", tx_valid, out_port); end
    #2;
    reset = 1'b0;
    #1;
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("[TB] FAIL async_tx_valid got %b exp 0", tx_valid); end
    checks++; if (out_port !== 8'h00) begin errors++; $display("[TB] FAIL async_out_port got %h exp 00", out_port); end
    tick();
    rd(A_STAT, v);
    checks++; if (v !== 32'h00000001) begin errors++; $display("[TB] FAIL held_status got %h exp 00000001", v); end
    reset = 1'b1;
    tick();
    rd(A_STAT, v);
    checks++; if (v !== 32'h00000001) begin errors++; $display("[TB] FAIL post_status got %h exp 00000001", v); end
    rd(32'h30, v);
    checks++; if (v !== 32'hCAFEF00D) begin errors++; $display("[TB] FAIL post_ram30 got %h exp CAFEF00D", v); end
    tick();
    rd(32'h10, v);
    checks++; if (v !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL post_ram10 got %h exp DEADBEEF", v); end
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("[TB] FAIL post_tx_valid got %b exp 0", tx_valid); end
  endtask

  initial begin
    test_reset();
    test_ram();
    test_outport();
    test_fifo_fill();
    test_full_push_pop();
    test_back_to_back();
    test_timer();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mips_dmem_bridge.md
# mips_dmem_bridge

Data-side memory subsystem directly downstream of the single-cycle MIPS core's data port. It consumes the core's ALU address, store data and write strobe, and returns read data in the same cycle. Non-MMIO addresses go to an internal word RAM; the top 64 KiB go to memory-mapped peripherals:
- an 8-bit output port
- a byte transmit FIFO with a valid/ready handshake toward a serial sink
- an optional free-running cycle timer

## Interface

Parameters:
- RAM_WORDS, 64, data RAM depth in 32-bit words; power of 2, ≥ 4
- FIFO_DEPTH, 8, TX FIFO entries; power of 2, ≥ 2

Ports:
- clk  input  1  rising-edge clock, shared with the core
- reset  input  1  asynchronous, active-low reset (0 = reset)
- memwrite  input  1  store strobe from the core
- aluout  input  32  byte address from the core
- writedata  input  32  store data from the core
- readdata  output  32  load data to the core; combinational
- tx_data  output  8  FIFO head byte
- tx_valid  output  1  FIFO non-empty
- tx_ready  input  1  sink accepts tx_data this cycle
- out_port  output  8  output port register

## Operation

Decode:
- MMIO when aluout[31:16] == 16'hFFFF.
- Otherwise RAM, indexed by word aluout[log2(RAM_WORDS)+1:2]. Higher bits alias; aluout[1:0] is ignored (word access only).

MMIO map. The offset is aluout[15:0]; aluout[1:0] is ignored.
- 0x0000 OUTPORT: R/W. Read returns {24'b0, out_port}. Write loads writedata[7:0].
- 0x0004 TXDATA: W. A write pushes writedata[7:0] if the FIFO is not full; otherwise the byte is dropped and overflow is set. Read returns 0.
- 0x0008 STATUS: R.
  - Bit [0] = empty, [1] = full, [2] = overflow (sticky), [15:8] = count. All other bits 0.
  - A write with writedata[2] = 1 clears overflow; other write bits are ignored.
- 0x000C TIMER: R/W (MMIO_TIMER_EN). Read returns the counter. Write loads writedata.
- Any other MMIO offset: reads 0, writes ignored.

RAM:
- Read is combinational.
- Write occurs on the rising clk edge when memwrite = 1.
- Contents are not reset.

FIFO:
- Circular buffer with read/write pointers and a count of width log2(FIFO_DEPTH)+1. Pointers wrap modulo FIFO_DEPTH.
- tx_valid = (count != 0). tx_data = entry at the read pointer; its value is don't-care when empty.
- Pop occurs when tx_valid & tx_ready.
- Push and pop in the same cycle with a non-full FIFO: both occur and count is unchanged.
- Push while full is dropped even if a pop occurs the same cycle, because full is sampled pre-edge. The pop still occurs and overflow is set.
- Overflow set and clear can only come from distinct addresses, so they never collide.

Timer:
- +1 every cycle, wrapping from 0xFFFFFFFF to 0.
- A write has priority over the increment: the loaded value is visible the next cycle and increments from then on.

## Timing

- readdata is valid in the same cycle as aluout (zero latency), as the single-cycle core requires.
- All state updates occur on the rising clk edge. The new value is visible on readdata the cycle after the write.
- A FIFO push makes tx_valid = 1 on the cycle after the write edge.
- The sink sees each byte for at least one cycle and holds tx_data stable until it is popped.
- Reset asserted (reset = 0), including mid-transfer:
  - Immediately and asynchronously, out_port = 0, count = 0, pointers = 0, overflow = 0, timer = 0 and tx_valid = 0.
  - Pending FIFO bytes are discarded.
  - STATUS reads 0x00000001 while reset is held.
- Reset release is synchronous to the first clk edge after reset = 1.

## Configuration

- MMIO_TIMER_EN defined: the 32-bit timer is present, as described above.
- MMIO_TIMER_EN undefined: no timer flops are built. Offset 0x000C reads 0 and writes are ignored. All other behaviour is unchanged.

## Test plan

- RAM: store 0xDEADBEEF at 0x0000_0010, then load 0x10 -> 0xDEADBEEF. Load 0x10 + RAM_WORDS*4 -> 0xDEADBEEF (alias). Load 0x13 -> same word.
- FIFO: with tx_ready = 0, write 0x41..0x48 to 0xFFFF0004 (8 pushes) -> STATUS = 0x00000802. A 9th write of 0x49 -> STATUS = 0x00000806. Raise tx_ready -> tx_data sequence 0x41..0x48, one per cycle, then tx_valid = 0 and STATUS = 0x00000005.
- Simultaneous events:
  - Full FIFO with tx_ready = 1 and a push -> pop occurs, push dropped, overflow = 1, count = 7.
  - Count = 3 with push + pop together -> count stays 3 and order is preserved.
  - Write 0x4 to STATUS -> bit 2 = 0.
- Output port: write 0x1234_56A5 to 0xFFFF0000 -> out_port = 0xA5, read = 0x000000A5. A write to 0xFFFF0020 -> no state change, read = 0.
- Timer (MMIO_TIMER_EN): write 0xFFFFFFFE, then read on the next 3 cycles -> 0xFFFFFFFE, 0xFFFFFFFF, 0x00000000. Without the macro, read 0xFFFF000C -> 0.
- Reset mid-operation: with 5 bytes queued and out_port = 0x3C, pull reset low between edges -> tx_valid = 0 and out_port = 0 immediately. After release, STATUS = 0x00000001 and RAM contents are unchanged.
